serial_frame_transmitter: RTL and testbench

- Downstream stage of the serial bit-collecting receiver.
- When the receiver signals that a byte is complete, this block latches the 8-bit parallel byte and retransmits it as a UART-style frame: start bit, data LSB first, optional parity, stop bit(s).
- It provides busy/done status and flags requests lost while a frame is in flight.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 29 ++
 rtl/serial_frame_transmitter.sv | 154 +++++++++++++++
 tb/tb_serial_frame_transmitter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmit path.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic LINE_IDLE      = 1'b1;
    localparam int   DEFAULT_DATA_W = 8;

    // Serial frame length in clock cycles (start + data + parity + stop bits).
    function automatic int frame_len(input int clks_per_bit, input int data_w,
                                     input int parity_en, input int stop_bits);
        return clks_per_bit * (1 + data_w + parity_en + stop_bits);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: bit_end is high on the last cycle of each CLKS_PER_BIT period.
// clear holds the counter at zero so the first period starts cleanly.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/serial_frame_transmitter.sv
// Latches a received byte on a wake rise and sends it as a start/data/parity/stop frame.
// serial_out starts the frame two edges after the wake rise; wakes while busy are dropped and flagged.
module serial_frame_transmitter
    import serial_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wake,
    input  logic [DATA_W-1:0] data_in,
    output logic              serial_out,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [DATA_W-1:0]   latched;
    logic                par;
    logic                wake_q;
    logic                rise;
    logic                bit_clear;
    logic                bit_end;
    logic                last_data;
    logic                last_stop;
    logic                frame_end;
    logic                accept;
    logic                serial_nxt;
    logic                busy_nxt;
    logic                overrun_nxt;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (bit_clear),
        .bit_end(bit_end)
    );

    assign rise      = wake && !wake_q;
    assign bit_clear = (state == IDLE) || (state == ARM);
    assign last_data = (idx == IDX_W'(DATA_W - 1));
    assign last_stop = (idx == IDX_W'(STOP_BITS - 1));
    assign frame_end = (state == STOP) && last_stop && bit_end;
    assign accept    = rise && ((state == IDLE) || frame_end);

    // wake_q resets high so a wake held across reset release is not taken as a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            latched    <= '0;
            par        <= 1'b0;
            wake_q     <= 1'b1;
            serial_out <= LINE_IDLE;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            wake_q     <= wake;
            serial_out <= serial_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            if (state == ARM) begin
                latched <= data_in;
                par     <= (^data_in) ^ (PARITY_ODD != 0);
            end
        end
    end

    // idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (rise) state_nxt = ARM;
            end
            ARM: begin
                state_nxt = START;
                idx_nxt   = '0;
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    idx_nxt   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_nxt = rise ? ARM : IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // The line value is chosen from the upcoming state so serial_out can be a flop.
    always_comb begin
        serial_nxt = LINE_IDLE;
        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = latched[idx_nxt];
            PARITY:  serial_nxt = par;
            default: serial_nxt = LINE_IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        if (accept) begin
            overrun_nxt = 1'b0;
        end else if (rise && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end else begin
            overrun_nxt = overrun;
        end
        done = frame_end;
    end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Drives four differently configured transmitters with shared stimulus and checks
// every cycle against a frame-position reference model, plus directed scenario checks.
module tb_serial_frame_transmitter;

    localparam int NDUT = 4;
    localparam int CPB_T [NDUT] = '{4, 1, 2, 4};
    localparam int PE_T  [NDUT] = '{1, 1, 1, 0};
    localparam int PO_T  [NDUT] = '{0, 0, 1, 0};
    localparam int SB_T  [NDUT] = '{1, 2, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       wake;
    logic [7:0] data_in;

    logic so_w [NDUT];
    logic bz_w [NDUT];
    logic dn_w [NDUT];
    logic ov_w [NDUT];

    int checks = 0;
    int errors = 0;

    logic so_log [NDUT][80];
    logic bz_log [NDUT][80];
    logic dn_log [NDUT][80];
    logic ov_log [NDUT][80];

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp_v, $time);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int CPB = CPB_T[g];
        localparam int PE  = PE_T[g];
        localparam int PO  = PO_T[g];
        localparam int SB  = SB_T[g];
        localparam int NB  = 1 + 8 + PE + SB;
        localparam int FL  = serial_pkg::frame_len(CPB, 8, PE, SB);

        serial_frame_transmitter #(
            .DATA_W      (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .wake      (wake),
            .data_in   (data_in),
            .serial_out(so_w[g]),
            .busy      (bz_w[g]),
            .done      (dn_w[g]),
            .overrun   (ov_w[g])
        );

        // Model: m_pos counts cycles since acceptance (0 = arm cycle, FL = last stop cycle).
        bit m_act   = 1'b0;
        int m_pos   = 0;
        bit m_wprev = 1'b1;
        bit m_ovr   = 1'b0;
        bit m_bits [NB];
        bit rise;

        initial begin
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    m_act   = 1'b0;
                    m_pos   = 0;
                    m_wprev = 1'b1;
                    m_ovr   = 1'b0;
                end else begin
                    rise    = wake && !m_wprev;
                    m_wprev = wake;
                    if (!m_act) begin
                        if (rise) begin
                            m_act = 1'b1;
                            m_pos = 0;
                            m_ovr = 1'b0;
                        end
                    end else if (m_pos == FL) begin
                        if (rise) begin
                            m_pos = 0;
                            m_ovr = 1'b0;
                        end else begin
                            m_act = 1'b0;
                        end
                    end else begin
                        if (rise) m_ovr = 1'b1;
                        m_pos++;
                        if (m_pos == 1) begin
                            m_bits[0] = 1'b0;
                            for (int k = 0; k < 8; k++) m_bits[1 + k] = data_in[k];
                            if (PE != 0) m_bits[9] = (^data_in) ^ (PO != 0);
                            for (int s = 0; s < SB; s++) m_bits[9 + PE + s] = 1'b1;
                        end
                    end
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                check($sformatf("d%0d_serial", g), so_w[g],
                      (m_act && m_pos >= 1) ? int'(m_bits[(m_pos - 1) / CPB]) : 1);
                check($sformatf("d%0d_busy", g), bz_w[g], int'(m_act));
                check($sformatf("d%0d_done", g), dn_w[g], int'(m_act && m_pos == FL));
                check($sformatf("d%0d_overrun", g), ov_w[g], int'(m_ovr));
            end
        end
    end

    // One wake pulse, then n cycles logged; optional second pulse at extra_i.
    task automatic frame_log(input logic [7:0] d, input int n, input int extra_i);
        @(negedge clk);
        wake    = 1'b1;
        data_in = d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                so_log[g][i] = so_w[g];
                bz_log[g][i] = bz_w[g];
                dn_log[g][i] = dn_w[g];
                ov_log[g][i] = ov_w[g];
            end
            wake = (i == extra_i);
            if (i == extra_i) data_in = d;
            else if (i >= 1 && i != extra_i + 1) data_in = 8'($urandom);
        end
    endtask

    function automatic int count_busy(input int g, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(bz_log[g][i]);
        return c;
    endfunction

    function automatic int count_done(input int g, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(dn_log[g][i]);
        return c;
    endfunction

    int exp_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int exp_ff [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        rst     = 1'b1;
        wake    = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_serial", so_w[0], 1);
        check("rst_busy", bz_w[0], 0);
        check("rst_done", dn_w[0], 0);
        check("rst_overrun", ov_w[0], 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Even parity frame of 0xA5.
        frame_log(8'hA5, 60, -1);
        check("a5_busy_len", count_busy(0, 60), 45);
        check("a5_done_cnt", count_done(0, 60), 1);
        check("a5_done_at44", dn_log[0][44], 1);
        check("a5_arm_idle", so_log[0][0], 1);
        for (int k = 0; k < 11; k++)
            check($sformatf("a5_bit%0d", k), so_log[0][2 + 4 * k], exp_a5[k]);
        check("nopar_busy_len", count_busy(3, 60), 41);
        check("stop2_busy_len", count_busy(1, 60), 13);

        // Parity of 0x07: odd config gives 0, even config gives 1.
        frame_log(8'h07, 60, -1);
        check("odd_par_07", so_log[2][19], 0);
        check("even_par_07", so_log[0][38], 1);

        // Wake mid-DATA is dropped and flagged.
        frame_log(8'h5A, 60, 20);
        check("ovr_set", ov_log[0][25], 1);
        check("ovr_busy_len", count_busy(0, 60), 45);
        check("ovr_done_cnt", count_done(0, 60), 1);
        frame_log(8'hA3, 60, -1);
        check("ovr_cleared", ov_log[0][0], 0);
        check("ovr_next_len", count_busy(0, 60), 45);

        // Wake in the done cycle chains a second frame with no idle gap.
        frame_log(8'h3C, 70, 44);
        check("chain_done", dn_log[0][44], 1);
        check("chain_busy", bz_log[0][45], 1);
        check("chain_arm", so_log[0][45], 1);
        check("chain_start", so_log[0][46], 0);
        check("chain_no_ovr", ov_log[0][45], 0);
        check("chain_bit0", so_log[0][51], 0);
        check("chain_bit2", so_log[0][59], 1);
        repeat (40) @(negedge clk);

        // Asynchronous reset during DATA bit 3, wake held high across release.
        @(negedge clk);
        wake    = 1'b1;
        data_in = 8'hC3;
        @(negedge clk);
        wake = 1'b0;
        repeat (18) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_serial", so_w[0], 1);
        check("arst_busy", bz_w[0], 0);
        check("arst_done", dn_w[0], 0);
        wake = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        for (int g = 0; g < NDUT; g++) check($sformatf("held_wake_idle%0d", g), bz_w[g], 0);
        wake = 1'b0;
        @(negedge clk);
        wake = 1'b1;
        @(negedge clk);
        check("fresh_edge_busy", bz_w[0], 1);
        wake = 1'b0;
        repeat (60) @(negedge clk);

        // Two stop bits at one clock per bit, 0xFF.
        frame_log(8'hFF, 20, -1);
        for (int k = 0; k < 12; k++)
            check($sformatf("ff_bit%0d", k), so_log[1][1 + k], exp_ff[k]);
        check("ff_done", dn_log[1][12], 1);
        check("ff_done_early", dn_log[1][11], 0);
        repeat (40) @(negedge clk);

        // Random requests, hold lengths, gaps and data churn.
        for (int n = 0; n < 40; n++) begin
            int hold;
            int gap;
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 60);
            @(negedge clk);
            wake    = 1'b1;
            data_in = 8'($urandom);
            repeat (hold) @(negedge clk);
            wake = 1'b0;
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                data_in = 8'($urandom);
            end
        end
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
